// File: rtl/change_dispenser.sv
// Change dispenser: plans exact change from a latched coin inventory with a greedy
// 10/5/1 split, then ejects coins one at a time with an ack handshake and timeout.
module change_dispenser #(
    parameter int W_AMT       = 5,
    parameter int W_CNT       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [W_AMT-1:0] i_change,
    input  logic [W_CNT-1:0] i_am_1,
    input  logic [W_CNT-1:0] i_am_5,
    input  logic [W_CNT-1:0] i_am_10,
    input  logic             i_coin_ack,
    output logic             o_busy,
    output logic             o_coin_1,
    output logic             o_coin_5,
    output logic             o_coin_10,
    output logic             o_done,
    output logic             o_no_change,
    output logic             o_fault,
    output logic [W_CNT-1:0] o_used_1,
    output logic [W_CNT-1:0] o_used_5,
    output logic [W_CNT-1:0] o_used_10
);

    // Planning arithmetic width: wide enough for 10*n10 (W_AMT+1) and for any count.
    localparam int W_MAX = (W_AMT + 1 > W_CNT) ? W_AMT + 1 : W_CNT;
    localparam int W_TMR = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SELECT,
        S_DROP,
        S_DONE,
        S_FAIL,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [W_AMT-1:0] amt_q, amt_d;
    logic [W_CNT-1:0] am_1_q, am_1_d;
    logic [W_CNT-1:0] am_5_q, am_5_d;
    logic [W_CNT-1:0] am_10_q, am_10_d;
    logic [W_CNT-1:0] plan_1_q, plan_1_d;
    logic [W_CNT-1:0] plan_5_q, plan_5_d;
    logic [W_CNT-1:0] plan_10_q, plan_10_d;
    logic [W_CNT-1:0] used_1_q, used_1_d;
    logic [W_CNT-1:0] used_5_q, used_5_d;
    logic [W_CNT-1:0] used_10_q, used_10_d;
    logic [W_TMR-1:0] timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             coin_1_q, coin_1_d;
    logic             coin_5_q, coin_5_d;
    logic             coin_10_q, coin_10_d;
    logic             done_q, done_d;
    logic             no_change_q, no_change_d;
    logic             fault_q, fault_d;

    // Greedy plan from the latched snapshot; exact for the 1/5/10 coin set.
    logic [W_MAX-1:0] amt_x, q10, n10, r1, q5, n5, r2, n1, r3;
    logic             feasible;

    always_comb begin
        amt_x    = W_MAX'(amt_q);
        q10      = amt_x / W_MAX'(10);
        n10      = (q10 < W_MAX'(am_10_q)) ? q10 : W_MAX'(am_10_q);
        r1       = amt_x - n10 * W_MAX'(10);
        q5       = r1 / W_MAX'(5);
        n5       = (q5 < W_MAX'(am_5_q)) ? q5 : W_MAX'(am_5_q);
        r2       = r1 - n5 * W_MAX'(5);
        n1       = (r2 < W_MAX'(am_1_q)) ? r2 : W_MAX'(am_1_q);
        r3       = r2 - n1;
        feasible = (r3 == '0);
    end

    // NOTE: every register's next value defaults to its current value first, so no
    // path through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        amt_d       = amt_q;
        am_1_d      = am_1_q;
        am_5_d      = am_5_q;
        am_10_d     = am_10_q;
        plan_1_d    = plan_1_q;
        plan_5_d    = plan_5_q;
        plan_10_d   = plan_10_q;
        used_1_d    = used_1_q;
        used_5_d    = used_5_q;
        used_10_d   = used_10_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        coin_1_d    = coin_1_q;
        coin_5_d    = coin_5_q;
        coin_10_d   = coin_10_q;
        done_d      = 1'b0;
        no_change_d = 1'b0;
        fault_d     = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    amt_d     = i_change;
                    am_1_d    = i_am_1;
                    am_5_d    = i_am_5;
                    am_10_d   = i_am_10;
                    used_1_d  = '0;
                    used_5_d  = '0;
                    used_10_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CHECK;
                end
            end

            S_CHECK: begin
                if (feasible) begin
                    plan_10_d = W_CNT'(n10);
                    plan_5_d  = W_CNT'(n5);
                    plan_1_d  = W_CNT'(n1);
                    state_d   = S_SELECT;
                end else begin
                    no_change_d = 1'b1;
                    state_d     = S_FAIL;
                end
            end

            S_SELECT: begin
                timer_d = '0;
                if (plan_10_q != '0) begin
                    coin_10_d = 1'b1;
                    state_d   = S_DROP;
                end else if (plan_5_q != '0) begin
                    coin_5_d = 1'b1;
                    state_d  = S_DROP;
                end else if (plan_1_q != '0) begin
                    coin_1_d = 1'b1;
                    state_d  = S_DROP;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DROP: begin
                if (i_coin_ack) begin
                    if (coin_10_q) begin
                        plan_10_d = plan_10_q - W_CNT'(1);
                        used_10_d = used_10_q + W_CNT'(1);
                    end
                    if (coin_5_q) begin
                        plan_5_d = plan_5_q - W_CNT'(1);
                        used_5_d = used_5_q + W_CNT'(1);
                    end
                    if (coin_1_q) begin
                        plan_1_d = plan_1_q - W_CNT'(1);
                        used_1_d = used_1_q + W_CNT'(1);
                    end
                    coin_1_d  = 1'b0;
                    coin_5_d  = 1'b0;
                    coin_10_d = 1'b0;
                    timer_d   = '0;
                    state_d   = S_SELECT;
                end else if (timer_q == W_TMR'(ACK_TIMEOUT - 1)) begin
                    // Line has been high for ACK_TIMEOUT cycles with no ack.
                    coin_1_d  = 1'b0;
                    coin_5_d  = 1'b0;
                    coin_10_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    timer_d = timer_q + W_TMR'(1);
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_FAIL: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            amt_q       <= '0;
            am_1_q      <= '0;
            am_5_q      <= '0;
            am_10_q     <= '0;
            plan_1_q    <= '0;
            plan_5_q    <= '0;
            plan_10_q   <= '0;
            used_1_q    <= '0;
            used_5_q    <= '0;
            used_10_q   <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            coin_1_q    <= 1'b0;
            coin_5_q    <= 1'b0;
            coin_10_q   <= 1'b0;
            done_q      <= 1'b0;
            no_change_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            amt_q       <= amt_d;
            am_1_q      <= am_1_d;
            am_5_q      <= am_5_d;
            am_10_q     <= am_10_d;
            plan_1_q    <= plan_1_d;
            plan_5_q    <= plan_5_d;
            plan_10_q   <= plan_10_d;
            used_1_q    <= used_1_d;
            used_5_q    <= used_5_d;
            used_10_q   <= used_10_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            coin_1_q    <= coin_1_d;
            coin_5_q    <= coin_5_d;
            coin_10_q   <= coin_10_d;
            done_q      <= done_d;
            no_change_q <= no_change_d;
            fault_q     <= fault_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_coin_1    = coin_1_q;
    assign o_coin_5    = coin_5_q;
    assign o_coin_10   = coin_10_q;
    assign o_done      = done_q;
    assign o_no_change = no_change_q;
    assign o_fault     = fault_q;
    assign o_used_1    = used_1_q;
    assign o_used_5    = used_5_q;
    assign o_used_10   = used_10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hand-computed expectations checked with
// immediate assertions, sampled 1 time unit after each rising edge.
module tb_change_dispenser;

    localparam int W_AMT       = 5;
    localparam int W_CNT       = 6;
    localparam int ACK_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic [W_AMT-1:0] i_change;
    logic [W_CNT-1:0] i_am_1;
    logic [W_CNT-1:0] i_am_5;
    logic [W_CNT-1:0] i_am_10;
    logic             i_coin_ack;
    logic             o_busy;
    logic             o_coin_1;
    logic             o_coin_5;
    logic             o_coin_10;
    logic             o_done;
    logic             o_no_change;
    logic             o_fault;
    logic [W_CNT-1:0] o_used_1;
    logic [W_CNT-1:0] o_used_5;
    logic [W_CNT-1:0] o_used_10;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .W_AMT(W_AMT),
        .W_CNT(W_CNT),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_change(i_change),
        .i_am_1(i_am_1),
        .i_am_5(i_am_5),
        .i_am_10(i_am_10),
        .i_coin_ack(i_coin_ack),
        .o_busy(o_busy),
        .o_coin_1(o_coin_1),
        .o_coin_5(o_coin_5),
        .o_coin_10(o_coin_10),
        .o_done(o_done),
        .o_no_change(o_no_change),
        .o_fault(o_fault),
        .o_used_1(o_used_1),
        .o_used_5(o_used_5),
        .o_used_10(o_used_10)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] coins();
        return {o_coin_10, o_coin_5, o_coin_1};
    endfunction

    task automatic start(input logic [W_AMT-1:0] chg, input logic [W_CNT-1:0] a1,
                         input logic [W_CNT-1:0] a5, input logic [W_CNT-1:0] a10);
        i_change = chg;
        i_am_1   = a1;
        i_am_5   = a5;
        i_am_10  = a10;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
    endtask

    // Coin line must already be up; hold it for 'delay' more cycles, ack, check the gap.
    task automatic drop_coin(input string tag, input logic [2:0] exp_coin, input int delay);
        check({tag, "_rise"}, coins(), exp_coin);
        for (int k = 0; k < delay; k++) begin
            step();
            check({tag, "_hold"}, coins(), exp_coin);
        end
        i_coin_ack = 1'b1;
        step();
        i_coin_ack = 1'b0;
        check({tag, "_gap"}, coins(), 3'b000);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_change   = '0;
        i_am_1     = '0;
        i_am_5     = '0;
        i_am_10    = '0;
        i_coin_ack = 1'b0;
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_coins", coins(), 3'b000);
        check("rst_flags", {o_done, o_no_change, o_fault}, 3'b000);
        check("rst_used", {o_used_10, o_used_5, o_used_1}, 18'd0);
        #12;
        i_rst_n = 1'b1;
        step();
        check("idle_busy", o_busy, 1'b0);

        // Reset taken mid-DROP drops the coin line immediately.
        start(5'd5, 6'd0, 6'd1, 6'd0);
        check("mr_busy", o_busy, 1'b1);
        step();
        step();
        check("mr_coin5", coins(), 3'b010);
        i_rst_n = 1'b0;
        #1;
        check("mr_coin_off", coins(), 3'b000);
        check("mr_busy_off", o_busy, 1'b0);
        #2;
        i_rst_n = 1'b1;
        step();
        check("mr_idle", {o_busy, coins()}, 4'b0000);
        step();
        check("mr_idle2", o_busy, 1'b0);

        // 17 from 6/2/1 -> 10,5,1,1.
        start(5'd17, 6'd6, 6'd2, 6'd1);
        check("c17_busy", o_busy, 1'b1);
        step();
        check("c17_nocoin_t1", coins(), 3'b000);
        step();
        drop_coin("c17_10", 3'b100, 2);
        drop_coin("c17_5", 3'b010, 2);
        drop_coin("c17_1a", 3'b001, 2);
        drop_coin("c17_1b", 3'b001, 2);
        check("c17_done", {o_done, o_busy}, 2'b11);
        step();
        check("c17_done_end", {o_done, o_busy}, 2'b00);
        check("c17_used1", o_used_1, 6'd2);
        check("c17_used5", o_used_5, 6'd1);
        check("c17_used10", o_used_10, 6'd1);

        // 8 from 2/1/0 is infeasible: o_no_change at T+2, used cleared, no coin.
        start(5'd8, 6'd2, 6'd1, 6'd0);
        check("c8_t1", {o_busy, o_no_change, coins()}, 5'b10000);
        step();
        check("c8_nochg", {o_busy, o_no_change, coins()}, 5'b11000);
        step();
        check("c8_end", {o_busy, o_no_change, coins()}, 5'b00000);
        check("c8_used", {o_used_10, o_used_5, o_used_1}, 18'd0);
        step();
        check("c8_idle", {o_busy, coins()}, 4'b0000);

        // Amount 0: done at T+3, busy T+1..T+3.
        start(5'd0, 6'd6, 6'd2, 6'd1);
        check("c0_t1", {o_busy, o_done}, 2'b10);
        step();
        check("c0_t2", {o_busy, o_done, coins()}, 5'b10000);
        step();
        check("c0_t3", {o_busy, o_done, coins()}, 5'b11000);
        step();
        check("c0_t4", {o_busy, o_done}, 2'b00);

        // 20 from 0/2/1 -> 10,5,5; start during DROP ignored.
        start(5'd20, 6'd0, 6'd2, 6'd1);
        step();
        step();
        check("c20_10", coins(), 3'b100);
        i_change = 5'd3;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
        check("c20_ign_start", {o_busy, coins()}, 4'b1100);
        drop_coin("c20_10", 3'b100, 1);
        drop_coin("c20_5a", 3'b010, 0);
        drop_coin("c20_5b", 3'b010, 3);
        check("c20_done", {o_done, o_busy}, 2'b11);
        step();
        check("c20_end", {o_done, o_busy}, 2'b00);
        check("c20_used", {o_used_10, o_used_5, o_used_1}, {6'd1, 6'd2, 6'd0});
        i_coin_ack = 1'b1;
        step();
        step();
        i_coin_ack = 1'b0;
        check("spur_ack", {o_busy, o_done, coins()}, 5'b00000);
        check("spur_used", {o_used_10, o_used_5, o_used_1}, {6'd1, 6'd2, 6'd0});

        // 10 with no ack: coin high ACK_TIMEOUT cycles, then sticky fault.
        start(5'd10, 6'd0, 6'd0, 6'd1);
        step();
        step();
        check("to_rise", coins(), 3'b100);
        for (int k = 1; k < ACK_TIMEOUT; k++) begin
            step();
            check("to_hold", coins(), 3'b100);
        end
        step();
        check("to_drop", coins(), 3'b000);
        check("to_fault", {o_fault, o_busy, o_done}, 3'b110);
        start(5'd0, 6'd0, 6'd0, 6'd0);
        i_coin_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("flt_stuck", {o_fault, o_busy, o_done, coins()}, 6'b110000);
        end
        i_coin_ack = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("flt_rst", {o_fault, o_busy}, 2'b00);
        #2;
        i_rst_n = 1'b1;
        step();
        check("flt_cleared", {o_fault, o_busy}, 2'b00);

        // Normal operation after fault reset: 1 from 1/0/0.
        start(5'd1, 6'd1, 6'd0, 6'd0);
        step();
        step();
        drop_coin("post_1", 3'b001, 0);
        check("post_done", {o_done, o_used_1}, {1'b1, 6'd1});
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays change out of the vending machine, one coin at a time. It is the outbound counterpart of the coin-intake path.
- Takes a change amount and a snapshot of the coin inventory, checks that exact change is possible, then drives one coin-eject line at a time. Each coin is handshaked with the eject mechanism.
- Reports per-denomination usage counts so the inventory keeper can decrement its stock.

Parameters:
- W_AMT, 5, width of change amount (max 31)
- W_CNT, 6, width of inventory/usage counts
- ACK_TIMEOUT, 15, cycles to wait for i_coin_ack before declaring a fault

Ports:
- clk  in  1  system clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle request to dispense i_change
- i_change  in  W_AMT  change amount in units of 1
- i_am_1  in  W_CNT  1-coins available, sampled on accepted start
- i_am_5  in  W_CNT  5-coins available, sampled on accepted start
- i_am_10  in  W_CNT  10-coins available, sampled on accepted start
- i_coin_ack  in  1  mechanism confirms current coin dropped
- o_busy  out  1  high from accepted start until return to IDLE
- o_coin_1  out  1  eject a 1-coin; level, held until ack
- o_coin_5  out  1  eject a 5-coin; level, held until ack
- o_coin_10  out  1  eject a 10-coin; level, held until ack
- o_done  out  1  one-cycle pulse: transaction complete
- o_no_change  out  1  one-cycle pulse: exact change impossible, nothing dispensed
- o_fault  out  1  sticky: ack timeout
- o_used_1  out  W_CNT  1-coins dispensed this transaction
- o_used_5  out  W_CNT  5-coins dispensed this transaction
- o_used_10  out  W_CNT  10-coins dispensed this transaction

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0, state IDLE, internal registers cleared.
  - Takes effect immediately, including mid-DROP: the coin line drops the same instant.
- States: IDLE, CHECK, SELECT, DROP, DONE, FAIL, FAULT. All outputs are registered.
- IDLE:
  - On i_start: latch i_change and i_am_*, clear o_used_*, set o_busy, go to CHECK.
  - i_start while o_busy=1 is ignored.
- CHECK (1 cycle): greedy plan, exact for the 1/5/10 denomination set.
  - n10 = min(amt/10, am10); r = amt - 10*n10.
  - n5 = min(r/5, am5); r = r - 5*n5.
  - n1 = min(r, am1); r = r - n1.
  - r == 0 -> store n10/n5/n1 as remaining plan, go to SELECT. Otherwise go to FAIL.
- SELECT (1 cycle):
  - Pick the largest denomination with remaining plan > 0, assert its o_coin_x (exactly one line high), go to DROP.
  - All plan counts 0 -> go to DONE.
- DROP:
  - Hold o_coin_x high and run the timeout counter.
  - i_coin_ack (may arrive in the first DROP cycle): deassert o_coin_x, decrement plan, increment o_used_x, clear the timer, go to SELECT.
  - Counter reaches ACK_TIMEOUT without ack: deassert the coin line, set o_fault, go to FAULT.
- DONE: o_done=1 for one cycle, o_busy=0 on the next cycle, go to IDLE. o_used_* hold until the next accepted start.
- FAIL: o_no_change=1 for one cycle, o_used_* stay 0, go to IDLE.
- FAULT: o_busy stays 1; all requests are ignored until reset.
- i_coin_ack outside DROP is ignored.
- No coin is ever ejected after an infeasible CHECK.
- Latency, start accepted at edge T:
  - Amount 0: o_done high in cycle T+3.
  - Nonzero amount: first coin line rises at T+3.
  - Each ack in DROP is followed by the next coin line one cycle after SELECT (a 1-cycle gap with no coin line).
- Arithmetic:
  - Products 10*n10 use W_AMT+1 bits internally.
  - o_used_* never exceed the latched inventory, so they cannot wrap.

Test Plan:
- Reset: assert i_rst_n=0 mid-operation -> all outputs 0 immediately; after release, state IDLE with o_busy=0.
- Change 17, inventory 6/2/1, ack 2 cycles after each coin -> coins ejected in order 10,5,1,1; o_used_10/5/1 = 1/1/2; o_done one pulse; exactly one coin line high at any time.
- Change 8, inventory 1s=2, 5s=1, 10s=0 -> o_no_change one pulse at T+2; no coin line ever high; o_used_* = 0.
- Change 0 -> o_done at T+3, no coin lines; o_busy high for cycles T+1..T+3.
- Change 10, ack never given -> o_coin_10 high for ACK_TIMEOUT cycles, then low; o_fault=1 sticky; new i_start ignored; reset clears.
- Change 20, inventory 10s=1, 5s=2 -> coins 10,5,5; a second i_start during DROP is ignored; a spurious i_coin_ack in IDLE has no effect.
